// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity type codes and the
// parity helper that both the RX check and the TX generator use.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest word the parity helper accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PAR_MAXW = 256;

  function automatic logic calc_parity(input logic [PAR_MAXW-1:0] data,
                                       input logic                par_typ);
    logic p;
    case (par_typ)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = ^data;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, per-bit edge counter and bit sampler.
// UART_RX_MAJORITY_EN selects a 3-sample majority vote; otherwise one mid-bit sample.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic rx_in,
  input  logic cnt_run,
  output logic rx_s,
  output logic sample_bit,
  output logic sample_strobe,
  output logic bit_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] EDGE_MID  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    sync1_d    = rx_in;
    sync2_d    = sync1_q;
    edge_cnt_d = '0;
    if (cnt_run) begin
      edge_cnt_d = (edge_cnt_q == EDGE_LAST) ? '0 : edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign rx_s    = sync2_q;
  assign bit_end = (edge_cnt_q == EDGE_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] EDGE_EARLY = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] EDGE_LATE  = CW'(PRESCALE / 2 + 1);

  logic smp_a_q, smp_a_d;
  logic smp_b_q, smp_b_d;

  // The third vote is the live rx_s, so the decision lands on the late edge.
  always_comb begin
    smp_a_d = (edge_cnt_q == EDGE_EARLY) ? sync2_q : smp_a_q;
    smp_b_d = (edge_cnt_q == EDGE_MID)   ? sync2_q : smp_b_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      smp_a_q <= smp_a_d;
      smp_b_q <= smp_b_d;
    end
  end

  assign sample_strobe = (edge_cnt_q == EDGE_LATE);
  assign sample_bit    = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);
`else
  assign sample_strobe = (edge_cnt_q == EDGE_MID);
  assign sample_bit    = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver frame FSM, shift register and result pulses; build option
// UART_RX_MAJORITY_EN (in uart_rx_sampler) picks majority-vote sampling.
// state  | meaning
// IDLE   | line high, waiting for rx_s=0
// START  | checking the start bit, glitch returns to IDLE
// DATA   | shifting data bits LSB-first
// PARITY | comparing the parity bit
// STOP   | sampling stop bit, result pulse issued next cycle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 3,
  parameter int PRESCALE  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [2**DATAWIDTH-1:0]   P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err
);

  localparam int W = 2**DATAWIDTH;
  localparam logic [DATAWIDTH-1:0] LAST_BIT = DATAWIDTH'(W - 1);

  rx_state_e              state_q, state_d;
  logic [DATAWIDTH-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]           shift_q, shift_d;
  logic [W-1:0]           p_data_q, p_data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic                   par_mis_q, par_mis_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   serr_q, serr_d;

  logic rx_s;
  logic sample_bit;
  logic sample_strobe;
  logic bit_end;
  logic cnt_run;

  // Counter restarts whenever the FSM lands in IDLE, including the early exit from STOP.
  assign cnt_run = (state_d != IDLE);

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .rx_in         (RX_IN),
    .cnt_run       (cnt_run),
    .rx_s          (rx_s),
    .sample_bit    (sample_bit),
    .sample_strobe (sample_strobe),
    .bit_end       (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_mis_d = par_mis_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          par_mis_d = 1'b0;
        end
      end

      START: begin
        if (sample_strobe && sample_bit) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (sample_strobe) begin
          shift_d = {sample_bit, shift_q[W-1:1]};
        end
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (sample_strobe) begin
          par_mis_d = (sample_bit != calc_parity(PAR_MAXW'(shift_q), par_typ_q));
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (sample_strobe) begin
          state_d = IDLE;
          if (!sample_bit) begin
            serr_d = 1'b1;
          end else if (par_mis_q) begin
            perr_d = 1'b1;
          end else begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_mis_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_mis_q <= par_mis_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = valid_q;
  assign Par_Err    = perr_q;
  assign Stp_Err    = serr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table-driven frames, hand-written corner
// sequences and random frames scored against a frame-level reference model.
module tb_uart_rx_frame;

  localparam int P  = 8;
  localparam int NB = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int RES = P / 2 + 1;
`else
  localparam int RES = P / 2;
`endif

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PAR   = 3'b010;
  localparam logic [2:0] K_STP   = 3'b001;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  uart_rx_frame #(
    .DATAWIDTH (3),
    .PRESCALE  (P)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pdata_model = 8'h00;

  always @(negedge CLK) begin
    if (Data_Valid || Par_Err || Stp_Err) begin
      pulse_t p;
      p.cyc  = cyc;
      p.kind = {Data_Valid, Par_Err, Stp_Err};
      p.data = P_DATA;
      obs_q.push_back(p);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Frame-level rule: a low stop bit wins, then a wrong parity bit, else the word is delivered.
  function automatic void model(input logic [7:0] d, input logic pe, input logic flip,
                                input logic stop, output logic [2:0] k, output logic [7:0] pd);
    if (!stop) begin
      k  = K_STP;
      pd = pdata_model;
    end else if (pe && flip) begin
      k  = K_PAR;
      pd = pdata_model;
    end else begin
      k  = K_VALID;
      pd = d;
    end
  endfunction

  // Drives one whole frame starting now; returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic flip, input logic stop,
                            input logic [2:0] ekind, input logic [7:0] epd);
    int     c0;
    int     nbits;
    logic   par_bit;
    pulse_t e;
    c0      = cyc;
    nbits   = NB + (pe ? 1 : 0);
    par_bit = (^d) ^ pt ^ flip;
    PAR_EN  = pe;
    PAR_TYP = pt;
    RX_IN   = 1'b0;
    repeat (P) tick();
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < NB; i++) begin
      RX_IN = d[i];
      repeat (P) tick();
    end
    if (pe) begin
      RX_IN = par_bit;
      repeat (P) tick();
    end
    RX_IN = stop;
    repeat (P) tick();
    RX_IN  = 1'b1;
    e.cyc  = c0 + 2 + (nbits + 1) * P + RES + 1;
    e.kind = ekind;
    e.data = epd;
    exp_q.push_back(e);
    if (ekind == K_VALID) pdata_model = epd;
  endtask

  task automatic send_model(input logic [7:0] d, input logic pe, input logic pt,
                            input logic flip, input logic stop);
    logic [2:0] k;
    logic [7:0] pd;
    model(d, pe, flip, stop, k, pd);
    send_frame(d, pe, pt, flip, stop, k, pd);
  endtask

  task automatic check_pulses(input string name);
    pulse_t e;
    pulse_t o;
    RX_IN = 1'b1;
    repeat (2 * P) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s missing pulse: expected kind=%b data=%h at cycle %0d", name, e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.kind != e.kind || o.data != e.data) begin
          errors++;
          $display("FAIL %s pulse got kind=%b data=%h cycle=%0d expected kind=%b data=%h cycle=%0d",
                   name, o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra pulses got=%0d expected=0 (first kind=%b data=%h cycle=%0d)",
               name, obs_q.size(), obs_q[0].kind, obs_q[0].data, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       flip;
    logic       stop;
    logic [2:0] kind;
    logic [7:0] pd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h3C};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR,   8'h3C};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, K_STP,   8'h3C};
    tbl[4] = '{8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, K_VALID, 8'h0F};
    tbl[5] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, K_STP,   8'h0F};

    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (3) tick();
    chk("reset_p_data", 32'(P_DATA), 32'h0);
    chk("reset_pulses", 32'({Data_Valid, Par_Err, Stp_Err}), 32'h0);
    RST = 1'b1;
    repeat (P) tick();

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].flip, tbl[i].stop, tbl[i].kind, tbl[i].pd);
      check_pulses($sformatf("table%0d", i));
      chk($sformatf("table%0d_hold", i), 32'(P_DATA), 32'(tbl[i].pd));
    end

    // Two-cycle low glitch must be rejected, then a clean frame accepted.
    RX_IN = 1'b0;
    repeat (2) tick();
    RX_IN = 1'b1;
    repeat (3 * P) tick();
    check_pulses("glitch");
    send_model(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("after_glitch");

    send_model(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    send_model(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("back_to_back");

    // Reset during data bit 4 of a 0xC3 frame.
    begin
      logic [7:0] d;
      d = 8'hC3;
      RX_IN = 1'b0;
      repeat (P) tick();
      for (int i = 0; i < 4; i++) begin
        RX_IN = d[i];
        repeat (P) tick();
      end
      RX_IN = d[4];
      repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("midreset_p_data", 32'(P_DATA), 32'h0);
      chk("midreset_pulses", 32'({Data_Valid, Par_Err, Stp_Err}), 32'h0);
      RX_IN = 1'b1;
      tick();
      RST = 1'b1;
      pdata_model = 8'h00;
      check_pulses("midreset");
    end
    send_model(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("after_reset");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic       pe, pt, flip, stop;
      int         gap;
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_model(d, pe, pt, flip, stop);
      // A low stop bit looks like a new start; leave the line idle long enough to reject it.
      gap = stop ? $urandom_range(0, 6) : 2 * P;
      repeat (gap) tick();
    end
    check_pulses("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
